// File: rtl/pc_hazard_ctrl.sv
// pc_hazard_ctrl: ID-stage sequencer for the program counter and the IF/ID,
// ID/EX pipeline registers. Detects load-use and branch-operand hazards,
// stalls for multi-cycle mul/div and implements a halt/resume state.
// All control outputs are combinational from state and inputs, so PC
// redirects and holds take effect in the same cycle the instruction sits in ID.
// Optional build macro PC_HAZARD_CTRL_PERF_EN: when defined, stall_cycles
// counts held-PC cycles (saturating); when undefined, no counter flops exist
// and stall_cycles is tied to 0.
module pc_hazard_ctrl #(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch,
  input  logic             id_branch_taken,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             id_muldiv,
  input  logic             id_halt,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             resume,
  output logic             pc_hold,
  output logic             pc_jump,
  output logic             pc_jump_reg,
  output logic             pc_branch,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  // Counter preload: the issue cycle runs in RUN, the remaining cycles stall.
  localparam logic [7:0] MD_INIT  = 8'(MULDIV_LAT - 1);
  localparam bit         MD_MULTI = (MULDIV_LAT > 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] md_cnt;
  logic [7:0] md_cnt_nxt;

  logic ex_lu_match;
  logic br_ex_match;
  logic br_mem_match;
  logic lu_haz;
  logic br_haz;
  logic haz;

  // A load in EX whose destination is a register the ID instruction reads.
  assign ex_lu_match = (ex_rd != 5'd0) &&
                       ((id_use_rs && (id_rs == ex_rd)) ||
                        (id_use_rt && (id_rt == ex_rd)));
  assign lu_haz      = ex_mem_read && ex_lu_match;

  // Branches and jr resolve in ID, so their operands must not be in flight
  // in EX (any register write) or in MEM (load data not yet forwarded).
  assign br_ex_match  = (ex_rd != 5'd0) &&
                        (((id_branch || id_jr) && (id_rs == ex_rd)) ||
                         (id_branch && (id_rt == ex_rd)));
  assign br_mem_match = (mem_rd != 5'd0) &&
                        (((id_branch || id_jr) && (id_rs == mem_rd)) ||
                         (id_branch && (id_rt == mem_rd)));
  assign br_haz       = (ex_reg_write && br_ex_match) ||
                        (mem_mem_read && br_mem_match);

  assign haz = lu_haz || br_haz;

  // State register and mul/div countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      md_cnt <= 8'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Next-state selection; a hazard re-evaluates the ID instruction next cycle.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      ST_RUN: begin
        if (!haz) begin
          if (id_halt) begin
            state_nxt = ST_HALT;
          end else if (id_muldiv && MD_MULTI) begin
            state_nxt  = ST_MD_BUSY;
            md_cnt_nxt = MD_INIT;
          end
        end
      end
      ST_MD_BUSY: begin
        md_cnt_nxt = md_cnt - 8'd1;
        if (md_cnt <= 8'd1) begin
          state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt  = ST_RUN;
        md_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Output decode; every output is forced low while reset is held.
  always_comb begin
    pc_hold     = 1'b0;
    pc_jump     = 1'b0;
    pc_jump_reg = 1'b0;
    pc_branch   = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    md_busy     = 1'b0;
    if (!rst) begin
      case (state)
        ST_RUN: begin
          if (haz) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
          end else if (id_jr) begin
            pc_jump_reg = 1'b1;
            ifid_flush  = 1'b1;
          end else if (id_jump) begin
            pc_jump     = 1'b1;
            ifid_flush  = 1'b1;
          end else if (id_branch && id_branch_taken) begin
            pc_branch   = 1'b1;
            ifid_flush  = 1'b1;
          end
        end
        ST_MD_BUSY: begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          md_busy     = 1'b1;
        end
        ST_HALT: begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          halted      = 1'b1;
        end
        default: begin
          pc_hold = 1'b0;
        end
      endcase
    end
  end

`ifdef PC_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Count every cycle the PC is frozen, sticking at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (pc_hold) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign stall_cycles = rst ? '0 : stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Self-checking bench for pc_hazard_ctrl: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// behavioural model of the sequencer.
module tb_pc_hazard_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 6;
  localparam longint CMAX = (64'd1 << CW) - 1;
`ifdef PC_HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_rd, mem_rd;
  logic          id_use_rs, id_use_rt, id_branch, id_branch_taken;
  logic          id_jump, id_jr, id_muldiv, id_halt;
  logic          ex_reg_write, ex_mem_read, mem_mem_read, resume;
  logic          pc_hold, pc_jump, pc_jump_reg, pc_branch;
  logic          ifid_hold, ifid_flush, idex_bubble, halted, md_busy;
  logic [CW-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  pc_hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch(id_branch), .id_branch_taken(id_branch_taken),
    .id_jump(id_jump), .id_jr(id_jr), .id_muldiv(id_muldiv), .id_halt(id_halt),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .resume(resume),
    .pc_hold(pc_hold), .pc_jump(pc_jump), .pc_jump_reg(pc_jump_reg),
    .pc_branch(pc_branch), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .halted(halted), .md_busy(md_busy),
    .stall_cycles(stall_cycles)
  );

  // Behavioural model: halt flag, remaining mul/div stall cycles, stall total.
  bit     m_halt  = 1'b0;
  int     m_busy  = 0;
  longint m_stall = 0;

  // Compare process: outputs are compared mid-cycle, then the model advances
  // using the inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    logic [8:0]    e_vec, a_vec;
    logic [CW-1:0] e_cnt;
    logic [4:0]    rd_reg[2];
    bit            rd_en[2];
    bit            op_en[2];
    logic [4:0]    pr_rd[2];
    bit            pr_en[2];
    bit            lu, br, hold;
    bit            e_jr, e_j, e_b;

    e_vec = '0;
    e_cnt = '0;
    if (rst) begin
      m_halt  = 1'b0;
      m_busy  = 0;
      m_stall = 0;
    end else begin
      e_cnt = PERF ? CW'((m_stall > CMAX) ? CMAX : m_stall) : '0;
      rd_reg = '{id_rs, id_rt};
      rd_en  = '{id_use_rs, id_use_rt};
      op_en  = '{id_branch || id_jr, id_branch};
      pr_rd  = '{ex_rd, mem_rd};
      pr_en  = '{ex_reg_write, mem_mem_read};
      lu = 1'b0;
      br = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (ex_mem_read && ex_rd != 0 && rd_en[i] && rd_reg[i] == ex_rd) lu = 1'b1;
        for (int p = 0; p < 2; p++)
          if (pr_en[p] && pr_rd[p] != 0 && op_en[i] && rd_reg[i] == pr_rd[p]) br = 1'b1;
      end
      e_jr = 1'b0; e_j = 1'b0; e_b = 1'b0;
      hold = 1'b0;
      if (m_busy > 0) begin
        hold   = 1'b1;
        m_busy = m_busy - 1;
        e_vec[0] = 1'b1;
      end else if (m_halt) begin
        hold = 1'b1;
        e_vec[1] = 1'b1;
        if (resume) m_halt = 1'b0;
      end else if (lu || br) begin
        hold = 1'b1;
      end else begin
        if (id_jr) e_jr = 1'b1;
        else if (id_jump) e_j = 1'b1;
        else if (id_branch && id_branch_taken) e_b = 1'b1;
        if (id_halt) m_halt = 1'b1;
        else if (id_muldiv) m_busy = LAT - 1;
      end
      // {pc_hold,pc_jump,pc_jump_reg,pc_branch,ifid_hold,ifid_flush,idex_bubble,halted,md_busy}
      e_vec[8] = hold;
      e_vec[7] = e_j;
      e_vec[6] = e_jr;
      e_vec[5] = e_b;
      e_vec[4] = hold;
      e_vec[3] = e_j | e_jr | e_b;
      e_vec[2] = hold;
      if (hold) m_stall = m_stall + 1;
    end
    a_vec = {pc_hold, pc_jump, pc_jump_reg, pc_branch, ifid_hold, ifid_flush,
             idex_bubble, halted, md_busy};
    total++;
    if (a_vec !== e_vec) begin
      bad++;
      $display("FAIL model_ctrl t=%0t: got %b want %b", $time, a_vec, e_vec);
    end
    total++;
    if (stall_cycles !== e_cnt) begin
      bad++;
      $display("FAIL model_stall t=%0t: got %0d want %0d", $time, stall_cycles, e_cnt);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
    id_use_rs = 0; id_use_rt = 0; id_branch = 0; id_branch_taken = 0;
    id_jump = 0; id_jr = 0; id_muldiv = 0; id_halt = 0;
    ex_reg_write = 0; ex_mem_read = 0; mem_mem_read = 0; resume = 0;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
    #2 chk("reset_outputs", {pc_hold, halted, md_busy, ifid_flush, stall_cycles}, 0);

    // Load-use: one stall, cleared once the load leaves EX; r0 never stalls.
    ex_mem_read = 1; ex_rd = 8; id_use_rs = 1; id_rs = 8;
    #2 chk("lu_hold", {pc_hold, ifid_hold, idex_bubble}, 3'b111);
    next_cycle(); ex_mem_read = 0;
    #2 chk("lu_release", {pc_hold, ifid_hold, idex_bubble}, 3'b000);
    next_cycle(); ex_mem_read = 1; ex_rd = 0; id_rs = 0;
    #2 chk("lu_r0", pc_hold, 0);

    // Mul/div: issue cycle runs, then LAT-1 held cycles.
    next_cycle(); clear_in(); id_muldiv = 1;
    #2 chk("md_issue", {md_busy, pc_hold}, 2'b00);
    for (int k = 0; k < LAT - 1; k++) begin
      next_cycle(); clear_in();
      #2 chk("md_busy", {md_busy, pc_hold}, 2'b11);
    end
    next_cycle();
    #2 chk("md_done", {md_busy, pc_hold}, 2'b00);
    chk("stall_after_lu_md", stall_cycles, PERF ? 4 : 0);

    // Taken branch, then the same branch behind an EX writer of its operand.
    id_branch = 1; id_branch_taken = 1;
    #2 chk("beq_taken", {pc_branch, ifid_flush, idex_bubble}, 3'b110);
    next_cycle(); ex_reg_write = 1; ex_rd = 9; id_rs = 9;
    #2 chk("beq_haz", {pc_hold, pc_branch}, 2'b10);
    next_cycle(); ex_reg_write = 0;
    #2 chk("beq_after", {pc_hold, pc_branch, ifid_flush}, 3'b011);

    // Redirect priority and hazard overriding a redirect.
    next_cycle(); clear_in(); id_jr = 1; id_jump = 1;
    #2 chk("prio_jr", {pc_jump_reg, pc_jump, pc_branch, ifid_flush}, 4'b1001);
    next_cycle(); clear_in(); id_jump = 1; ex_mem_read = 1; ex_rd = 5; id_use_rs = 1; id_rs = 5;
    #2 chk("jump_lu", {pc_hold, pc_jump, pc_jump_reg, pc_branch, ifid_flush}, 5'b10000);

    // Halt: resume alongside id_halt is ignored; a later resume releases.
    next_cycle(); clear_in(); id_halt = 1; resume = 1;
    #2 chk("halt_issue", halted, 0);
    next_cycle(); clear_in();
    #2 chk("halted", {halted, pc_hold}, 2'b11);
    next_cycle(); resume = 1;
    #2 chk("halt_resume_cyc", halted, 1);
    next_cycle(); clear_in();
    #2 chk("resumed", {halted, pc_hold}, 2'b00);

    // Reset in the middle of a mul/div stall.
    next_cycle(); id_muldiv = 1;
    next_cycle(); clear_in();
    #2 chk("md_pre_rst", md_busy, 1);
    next_cycle(); rst = 1;
    #2 chk("rst_zero", {pc_hold, pc_jump, pc_jump_reg, pc_branch, ifid_hold,
                        ifid_flush, idex_bubble, halted, md_busy}, 0);
    next_cycle(); rst = 0;
    #2 chk("md_after_rst", {md_busy, pc_hold}, 2'b00);

    // Randomized traffic with small register numbers for frequent matches.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      rst             = ($urandom_range(0, 99) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      mem_rd          = 5'($urandom_range(0, 3));
      id_use_rs       = 1'($urandom_range(0, 1));
      id_use_rt       = 1'($urandom_range(0, 1));
      id_branch       = ($urandom_range(0, 3) == 0);
      id_branch_taken = 1'($urandom_range(0, 1));
      id_jump         = ($urandom_range(0, 5) == 0);
      id_jr           = ($urandom_range(0, 5) == 0);
      id_muldiv       = ($urandom_range(0, 9) == 0);
      id_halt         = ($urandom_range(0, 14) == 0);
      ex_reg_write    = ($urandom_range(0, 2) == 0);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      mem_mem_read    = ($urandom_range(0, 2) == 0);
      resume          = ($urandom_range(0, 3) == 0);
    end

    // Saturation: sit in HALT long enough to pass the counter maximum.
    next_cycle(); clear_in(); rst = 1;
    next_cycle(); rst = 0; id_halt = 1;
    next_cycle(); clear_in();
    repeat (70) next_cycle();
    #2 chk("stall_sat", stall_cycles, PERF ? 32'(CMAX) : 0);
    chk("sat_halted", halted, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
